result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 126 ++++++++++++
 tb/tb_result_collector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Collects single-bit results from a 4-stage assembly line into bytes, tracking sample validity with a shadow shift register.
// Optional macro RESULT_COLLECTOR_PARITY_EN adds the registered even-parity output out_parity.
module result_collector (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic       in_valid,
    input  logic       f,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       overflow,
    output logic [2:0] bit_count,
    output logic       pipe_busy
`ifdef RESULT_COLLECTOR_PARITY_EN
    ,
    output logic       out_parity
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  v_q, v_d;
    logic        cap_pend_q, cap_pend_d;
    logic [6:0]  sh_q, sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        ovf_q, ovf_d;
    logic        offer;
    logic [7:0]  offer_byte;
`ifdef RESULT_COLLECTOR_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Valid shadow and bit capture. cap_pend is armed by the load edge that
    // shifts a valid tag out of v[3], so the capture lands on the following
    // edge whether or not that edge is itself a load.
    always_comb begin
        v_d        = v_q;
        cap_pend_d = 1'b0;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        offer      = 1'b0;
        offer_byte = {sh_q, f};
        if (load) begin
            v_d        = {v_q[2:0], in_valid};
            cap_pend_d = v_q[3];
        end
        if (cap_pend_q) begin
            sh_d      = {sh_q[5:0], f};
            bit_cnt_d = bit_cnt_q + 3'd1;
            offer     = (bit_cnt_q == 3'd7);
        end
    end

    // Output holding register: one-byte skid with sticky drop flag
    always_comb begin
        state_d    = state_q;
        out_byte_d = out_byte_q;
        ovf_d      = ovf_q;
        case (state_q)
            EMPTY: begin
                if (offer) begin
                    state_d    = FULL;
                    out_byte_d = offer_byte;
                end
            end
            FULL: begin
                if (offer) begin
                    if (out_ready) begin
                        out_byte_d = offer_byte;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

`ifdef RESULT_COLLECTOR_PARITY_EN
    assign parity_d = ^out_byte_d;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= EMPTY;
            v_q        <= 4'd0;
            cap_pend_q <= 1'b0;
            sh_q       <= 7'd0;
            bit_cnt_q  <= 3'd0;
            out_byte_q <= 8'd0;
            ovf_q      <= 1'b0;
`ifdef RESULT_COLLECTOR_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            cap_pend_q <= cap_pend_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            out_byte_q <= out_byte_d;
            ovf_q      <= ovf_d;
`ifdef RESULT_COLLECTOR_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = (state_q == FULL);
    assign overflow  = ovf_q;
    assign bit_count = bit_cnt_q;
    assign pipe_busy = |v_q;
`ifdef RESULT_COLLECTOR_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector; covers the parity output when RESULT_COLLECTOR_PARITY_EN is defined.
module tb_result_collector;

    logic       clk;
    logic       clear;
    logic       load;
    logic       in_valid;
    logic       f;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       overflow;
    logic [2:0] bit_count;
    logic       pipe_busy;
`ifdef RESULT_COLLECTOR_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  pat;
    logic [15:0] pat2;
    logic [6:0]  ldp;
    logic [9:0]  ivp;

    result_collector dut (
        .clk       (clk),
        .clear     (clear),
        .load      (load),
        .in_valid  (in_valid),
        .f         (f),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .overflow  (overflow),
        .bit_count (bit_count),
        .pipe_busy (pipe_busy)
`ifdef RESULT_COLLECTOR_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ld, input logic iv, input logic fb, input logic rdy);
        load      = ld;
        in_valid  = iv;
        f         = fb;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load      = 1'b0;
        in_valid  = 1'b0;
        f         = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b1;
    endtask

    initial begin
        clear     = 1'b1;
        load      = 1'b0;
        in_valid  = 1'b0;
        f         = 1'b0;
        out_ready = 1'b0;
        #2;
        clear = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_pipe_busy", pipe_busy, 0);
        @(posedge clk);
        #1;
        clear = 1'b1;

        // Eight back-to-back samples assemble 8'hB2
        pat = 8'hB2;
        for (int k = 0; k <= 12; k++) begin
            step(1'b1, k < 8, (k >= 5) ? pat[12 - k] : 1'b0, 1'b0);
            if (k == 7) chk("A_pipe_busy", pipe_busy, 1);
            if (k == 11) begin
                chk("A_bc_before", bit_count, 7);
                chk("A_valid_before", out_valid, 0);
            end
            if (k == 12) begin
                chk("A_out_valid", out_valid, 1);
                chk("A_out_byte", out_byte, 8'hB2);
                chk("A_bc_wrap", bit_count, 0);
                chk("A_overflow", overflow, 0);
                chk("A_pipe_idle", pipe_busy, 0);
`ifdef RESULT_COLLECTOR_PARITY_EN
                chk("A_parity_B2", out_parity, 0);
`endif
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("A_consumed", out_valid, 0);

        // Stalled line: one sample, captured one edge after the 5th load edge
        do_reset();
        ldp = 7'b1001111;
        for (int k = 0; k <= 8; k++) begin
            step((k < 7) ? ldp[6 - k] : 1'b0, k == 0, 1'b1, 1'b0);
            if (k == 6) chk("B_bc_before", bit_count, 0);
            if (k == 7) chk("B_bc_capture", bit_count, 1);
            if (k == 8) chk("B_bc_once", bit_count, 1);
        end

        // Alternating bubbles with f stuck high
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            step(1'b1, (k < 16) && (k % 2 == 0), 1'b1, 1'b0);
            if (k == 6) chk("C_bc_bubble", bit_count, 1);
            if (k == 18) chk("C_bc_seven", bit_count, 7);
            if (k == 19) begin
                chk("C_out_valid", out_valid, 1);
                chk("C_out_byte", out_byte, 8'hFF);
                chk("C_bc_wrap", bit_count, 0);
            end
            if (k == 21) chk("C_no_extra", bit_count, 0);
        end

        // Second byte arrives while first is unconsumed: dropped
        do_reset();
        pat2 = {8'hB2, 8'h5C};
        for (int k = 0; k <= 20; k++) begin
            step(1'b1, k < 16, (k >= 5) ? pat2[20 - k] : 1'b0, 1'b0);
            if (k == 12) chk("D_first_byte", out_byte, 8'hB2);
            if (k == 16) chk("D_stable", out_byte, 8'hB2);
            if (k == 19) chk("D_ovf_before", overflow, 0);
            if (k == 20) begin
                chk("D_kept_byte", out_byte, 8'hB2);
                chk("D_overflow", overflow, 1);
                chk("D_still_valid", out_valid, 1);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("D_drained", out_valid, 0);
        chk("D_ovf_sticky", overflow, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("D_ovf_sticky2", overflow, 1);

        // Second byte arrives on the same edge the first is consumed
        do_reset();
        pat2 = {8'hB3, 8'hA5};
        for (int k = 0; k <= 20; k++) begin
            step(1'b1, k < 16, (k >= 5) ? pat2[20 - k] : 1'b0, k == 20);
            if (k == 12) begin
                chk("E_first_byte", out_byte, 8'hB3);
`ifdef RESULT_COLLECTOR_PARITY_EN
                chk("E_parity_B3", out_parity, 1);
`endif
            end
            if (k == 20) begin
                chk("E_new_byte", out_byte, 8'hA5);
                chk("E_valid", out_valid, 1);
                chk("E_no_ovf", overflow, 0);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("E_drained", out_valid, 0);

        // Asynchronous reset mid-byte with tags in flight
        do_reset();
        ivp = 10'b1111101010;
        for (int k = 0; k <= 9; k++) begin
            step(1'b1, ivp[9 - k], 1'b1, 1'b0);
        end
        chk("F_bc_pre", bit_count, 5);
        chk("F_busy_pre", pipe_busy, 1);
        #3;
        clear = 1'b0;
        #1;
        chk("F_bc_async", bit_count, 0);
        chk("F_busy_async", pipe_busy, 0);
        chk("F_valid_async", out_valid, 0);
        chk("F_byte_async", out_byte, 0);
        chk("F_ovf_async", overflow, 0);
        @(posedge clk);
        #1;
        clear = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            step(1'b1, k == 0, 1'b1, 1'b0);
            if (k == 4) chk("F_no_early_cap", bit_count, 0);
            if (k == 5) chk("F_first_cap", bit_count, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
